// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_AUX  = 1'b1;
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant: round-robin when MEM_ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with port 0 always winning.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_pref,
  output logic       o_any,
  output logic       o_gnt
);

  assign o_any = |i_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Preference only matters when both ports contend.
  assign o_gnt = (i_valid == 2'b11) ? i_pref : ~i_valid[PORT_CPU];
`else
  logic w_unused_pref;
  assign w_unused_pref = i_pref;
  assign o_gnt         = ~i_valid[PORT_CPU];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port synchronous BRAM.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin grant); default is fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  err
);

  arb_state_t  r_state;
  logic        r_win;
  logic        r_in_range;
  logic        r_is_read;
  logic        r_rd0;
  logic        r_rd1;

  logic        w_any;
  logic        w_gnt;
  logic        w_pref;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_in_range;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_pref;
  assign w_pref = r_pref;
`else
  assign w_pref = PORT_CPU;
`endif

  arb_pick2 u_pick (
    .i_valid ({m1_valid, m0_valid}),
    .i_pref  (w_pref),
    .o_any   (w_any),
    .o_gnt   (w_gnt)
  );

  assign w_addr     = (w_gnt == PORT_AUX) ? m1_addr  : m0_addr;
  assign w_wdata    = (w_gnt == PORT_AUX) ? m1_wdata : m0_wdata;
  assign w_wstrb    = (w_gnt == PORT_AUX) ? m1_wstrb : m0_wstrb;
  assign w_in_range = (w_addr[31:2] < 30'(MEM_WORDS));

  // BRAM data arrives in the RESP cycle itself, so read data is steered by a
  // registered select rather than re-registered (which would cost a cycle).
  assign m0_rdata = r_rd0 ? ram_rdata : ERR_RDATA;
  assign m1_rdata = r_rd1 ? ram_rdata : ERR_RDATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_win      <= PORT_CPU;
      r_in_range <= 1'b0;
      r_is_read  <= 1'b0;
      r_rd0      <= 1'b0;
      r_rd1      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      err        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_pref     <= PORT_CPU;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          r_rd0    <= 1'b0;
          r_rd1    <= 1'b0;
          err      <= 1'b0;
          if (w_any) begin
            r_win      <= w_gnt;
            r_in_range <= w_in_range;
            r_is_read  <= (w_wstrb == 4'b0000);
            ram_en     <= w_in_range;
            ram_we     <= w_in_range ? w_wstrb : 4'b0000;
            ram_addr   <= w_addr[ADDR_WIDTH+1:2];
            ram_wdata  <= w_wdata;
            r_state    <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_pref     <= ~w_gnt;
`endif
          end
        end
        ACCESS: begin
          ram_en   <= 1'b0;
          ram_we   <= '0;
          m0_ready <= (r_win == PORT_CPU);
          m1_ready <= (r_win == PORT_AUX);
          r_rd0    <= (r_win == PORT_CPU) && r_in_range && r_is_read;
          r_rd1    <= (r_win == PORT_AUX) && r_in_range && r_is_read;
          err      <= ~r_in_range;
          r_state  <= RESP;
        end
        RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          r_rd0    <= 1'b0;
          r_rd1    <= 1'b0;
          err      <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural BRAM; covers either build of
// MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        err;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(4096), .ADDR_WIDTH(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .err       (err)
  );

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  initial begin
    logic exp_port;
    reset = 1'b1;
    req0(1'b0, '0, '0, '0);
    req1(1'b0, '0, '0, '0);
    mem[0] <= 32'hCAFEF00D;
    mem[5] <= 32'hDEADBEEF;
    mem[8] <= 32'h11223344;
    tick();
    tick();
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'h0);
    chk("rst_ram_en_we", {27'd0, ram_en, ram_we}, 32'h0);
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    reset = 1'b0;

    // Single CPU read of word 5
    req0(1'b1, 32'h14, 32'h0, 4'h0);
    tick();
    chk("rd_ram_en", {31'd0, ram_en}, 32'h1);
    chk("rd_ram_addr", {20'd0, ram_addr}, 32'h5);
    chk("rd_ram_we", {28'd0, ram_we}, 32'h0);
    chk("rd_early_ready", {31'd0, m0_ready}, 32'h0);
    tick();
    chk("rd_m0_ready", {31'd0, m0_ready}, 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_ready", {31'd0, m1_ready}, 32'h0);
    chk("rd_ram_en_off", {31'd0, ram_en}, 32'h0);
    req0(1'b0, '0, '0, '0);
    tick();
    chk("rd_ready_pulse", {31'd0, m0_ready}, 32'h0);

    // Port 1 byte write, then read-back
    req1(1'b1, 32'h20, 32'h000000AA, 4'b0001);
    tick();
    chk("wr_ram_en", {31'd0, ram_en}, 32'h1);
    chk("wr_ram_we", {28'd0, ram_we}, 32'h1);
    chk("wr_ram_addr", {20'd0, ram_addr}, 32'h8);
    chk("wr_ram_wdata", ram_wdata, 32'h000000AA);
    tick();
    chk("wr_m1_ready", {31'd0, m1_ready}, 32'h1);
    chk("wr_m1_rdata", m1_rdata, 32'h0);
    chk("wr_m0_ready", {31'd0, m0_ready}, 32'h0);
    req1(1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    tick();
    tick();
    chk("rb_m1_ready", {31'd0, m1_ready}, 32'h1);
    chk("rb_m1_rdata", m1_rdata, 32'h112233AA);
    req1(1'b0, '0, '0, '0);
    tick();

    // Contention: both ports hold valid across six accesses
    req0(1'b1, 32'h14, 32'h0, 4'h0);
    req1(1'b1, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_port = k[0];
`else
      exp_port = 1'b0;
`endif
      tick();
      chk("ct_access_noready", {30'd0, m1_ready, m0_ready}, 32'h0);
      tick();
      chk($sformatf("ct_grant%0d", k), {30'd0, m1_ready, m0_ready},
          exp_port ? 32'h2 : 32'h1);
      chk($sformatf("ct_rdata%0d", k), exp_port ? m1_rdata : m0_rdata,
          exp_port ? 32'h112233AA : 32'hDEADBEEF);
      if (k == 5) req0(1'b0, '0, '0, '0);
      tick();
      chk("ct_idle_noready", {30'd0, m1_ready, m0_ready}, 32'h0);
    end
    tick();
    tick();
    chk("ct_m1_after_drop", {30'd0, m1_ready, m0_ready}, 32'h2);
    chk("ct_m1_after_drop_rdata", m1_rdata, 32'h112233AA);
    req1(1'b0, '0, '0, '0);
    tick();

    // Out-of-range write aliases word 0 but must not touch it
    req0(1'b1, 32'h0001_0000, 32'h12345678, 4'hF);
    tick();
    chk("oor_ram_en_we", {27'd0, ram_en, ram_we}, 32'h0);
    chk("oor_no_err_yet", {31'd0, err}, 32'h0);
    tick();
    chk("oor_ready_err", {30'd0, m0_ready, err}, 32'h3);
    chk("oor_rdata", m0_rdata, 32'h0);
    chk("oor_ram_en_resp", {31'd0, ram_en}, 32'h0);
    req0(1'b0, '0, '0, '0);
    tick();
    chk("oor_err_pulse", {31'd0, err}, 32'h0);
    chk("oor_mem0", mem[0], 32'hCAFEF00D);

    // Reset during port 0 ACCESS
    req0(1'b1, 32'h14, 32'h0, 4'h0);
    tick();
    chk("rs_in_access", {31'd0, ram_en}, 32'h1);
    reset = 1'b1;
    req0(1'b0, '0, '0, '0);
    tick();
    chk("rs_ready", {30'd0, m1_ready, m0_ready}, 32'h0);
    chk("rs_ram", {27'd0, ram_en, ram_we}, 32'h0);
    chk("rs_err", {31'd0, err}, 32'h0);
    chk("rs_rdata", m0_rdata | m1_rdata, 32'h0);
    reset = 1'b0;
    req1(1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    chk("rs_m1_ram_en", {31'd0, ram_en}, 32'h1);
    chk("rs_no_m0_ready", {31'd0, m0_ready}, 32'h0);
    tick();
    chk("rs_m1_ready", {30'd0, m1_ready, m0_ready}, 32'h2);
    chk("rs_m1_rdata", m1_rdata, 32'h112233AA);
    req1(1'b0, '0, '0, '0);
    tick();
    chk("rs_m1_done", {30'd0, m1_ready, m0_ready}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester arbiter sharing the single-port on-chip program/data RAM of `system`.
- Port 0 is the PicoRV32 native memory interface; port 1 is a secondary master (boot loader / debug DMA).
- Each port uses the PicoRV32 valid/ready handshake.
- The block sequences every access through a small state machine and drives the synchronous BRAM with registered address, data and strobes.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `ADDR_WIDTH`, 12: RAM word-address width; must equal log2(`MEM_WORDS`).
- `clk` in 1: sole clock; everything sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `m0_valid` in 1: CPU request; held until `m0_ready`.
- `m0_addr` in 32: CPU byte address.
- `m0_wdata` in 32: CPU write data.
- `m0_wstrb` in 4: CPU byte write enables; 0 means read.
- `m0_ready` out 1: one-cycle completion pulse.
- `m0_rdata` out 32: read data, valid while `m0_ready`=1.
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`: same as port 0, for requester 1.
- `ram_en` out 1: BRAM enable.
- `ram_we` out 4: BRAM byte write enables.
- `ram_addr` out `ADDR_WIDTH`: word address, `mX_addr[ADDR_WIDTH+1:2]`.
- `ram_wdata` out 32: BRAM write data.
- `ram_rdata` in 32: BRAM read data, one cycle after `ram_en`.
- `err` out 1: one-cycle pulse on an out-of-range access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**: sample `m0_valid`/`m1_valid`.
  - If none is set, stay in IDLE.
  - Otherwise pick a winner, latch its addr/wdata/wstrb and a range flag, then go to ACCESS.
- **ACCESS**: drive the RAM from the latched values.
  - In range: `ram_en`=1, `ram_we`=latched wstrb.
  - Out of range (`addr[31:ADDR_WIDTH+2]` != 0): `ram_en`=0, no write.
  - Go to RESP.
- **RESP**: pulse `mX_ready` for the winner only.
  - `mX_rdata` = `ram_rdata` for an in-range read, else 32'h0.
  - Out-of-range access also pulses `err`.
  - Return to IDLE.
- Loser keeps `valid` high; it is served on the next IDLE evaluation.
- A write returns `mX_rdata`=0.
- Requests are not queued. Each port has at most one outstanding access, guaranteed by the handshake.
- Address bits [1:0] are ignored.

## Timing
- Request present in IDLE at cycle N: `ram_en` at N+1, `mX_ready` at N+2, FSM in IDLE at N+3.
- Back-to-back throughput is one access per 3 cycles.
- A requester that reasserts `valid` at N+3 is eligible that same cycle.
- Reset values: state=IDLE; `m0_ready`=`m1_ready`=0; `m0_rdata`=`m1_rdata`=0; `ram_en`=0; `ram_we`=0; `ram_addr`=0; `ram_wdata`=0; `err`=0; round-robin pointer=port 0 preferred.
- Reset mid-access, in ACCESS or RESP: the access is abandoned.
  - No `ready` pulse is issued.
  - A write whose `ram_en` was already asserted may have landed; one not yet asserted must not.
- `valid` dropping before `ready` is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE within 2 cycles.
- `mX_ready` is never high for both ports in the same cycle.
- All outputs are registered.

## Configuration
- Macro `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined**: round-robin.
  - A 1-bit pointer names the preferred port and flips to the other port after each grant.
  - With both valid, grants alternate 0,1,0,1.
- **Undefined**: fixed priority, port 0 always wins.
  - Port 1 is served only while `m0_valid`=0 in IDLE.
  - The pointer register is not built.

## Structure
- Package `mem_arb_pkg`:
  - State encoding typedef `arb_state_t` (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Port index constants `PORT_CPU`=0 and `PORT_AUX`=1.
  - `ERR_RDATA`=32'h0.
- One sub-module, `arb_pick2`: combinational two-way grant from `valid[1:0]` plus the preferred-port bit.
  - Contains the `MEM_ARB_ROUND_ROBIN_EN` selection.
  - Reused later for peripheral bus sharing.
- FSM, latches and RAM drive stay in `mem_arbiter`.

## Test plan
- **Single CPU read**: preload word 5 = 32'hDEADBEEF; `m0_addr`=32'h14, `m0_wstrb`=0 at cycle N -> `ram_en` at N+1, `m0_ready` at N+2 with `m0_rdata`=32'hDEADBEEF; `m1_ready` stays 0.
- **Byte write**: port 1 writes `m1_addr`=32'h20, `m1_wdata`=32'h000000AA, `m1_wstrb`=4'b0001 over word 32'h11223344 -> read-back gives 32'h112233AA; `m1_rdata`=0 on the write.
- **Contention, round-robin defined**: both ports valid continuously for 6 accesses -> grant order 0,1,0,1,0,1, one `ready` every 3 cycles.
- **Contention, macro undefined**: same stimulus; port 1 starves while `m0_valid`=1; port 1 gets the first grant after `m0_valid` drops.
- **Out of range**: `m0_addr`=32'h0001_0000 (`MEM_WORDS`=4096) write -> `ram_en` never asserted, `m0_ready` and `err` pulse together, `m0_rdata`=0, RAM contents unchanged.
- **Reset in ACCESS**: assert `reset` during port 0's ACCESS cycle -> no `m0_ready`; all outputs 0 the next cycle; after release, a fresh `m1` read completes in 3 cycles.
